pll_lock_supervisor: RTL
========================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth for pll_locked; legal range 2..4.
REQ-002 Parameter RST_CYCLES, default 16: number of cycles pll_rst is held per PLL reset pulse; minimum 1.
REQ-003 Parameter STABLE_CYCLES, default 1024: number of consecutive synchronised-locked cycles required before release; minimum 1.
REQ-004 Parameter TIMEOUT_CYCLES, default 65536: maximum number of cycles spent waiting for lock before re-resetting the PLL; minimum 2.
REQ-005 clk  input  1: free-running PLL reference clock; all logic is clocked on the rising edge of this clock.
REQ-006 rst  input  1: asynchronous, active-high reset.
REQ-007 pll_locked  input  1: PLL LOCK output, asynchronous to clk.
REQ-008 cnt_clr  input  1: synchronous clear of fault_count.
REQ-009 pll_rst  output  1: active-high PLL reset request, registered.
REQ-010 sys_rst  output  1: active-high reset for logic clocked by the PLL output, registered; consumers resynchronise it.
REQ-011 ready  output  1: high exactly when state is RUN, registered.
REQ-012 fault_count  output  8: saturating count of lock losses and lock timeouts.

Function
REQ-013 pll_locked shall pass through a SYNC_STAGES-flop synchroniser; "lk" below denotes the final synchroniser stage, and no other logic shall sample pll_locked.
REQ-014 The FSM shall have four states: PRST, WAIT, STAB and RUN.
REQ-015 The FSM shall use one shared cycle counter, sized for max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES), which is zeroed on every state transition.
REQ-016 PRST: pll_rst=1 and sys_rst=1; after RST_CYCLES cycles in PRST the FSM shall go to WAIT.
REQ-017 WAIT: pll_rst=0 and sys_rst=1; lk=1 -> STAB; if lk stays 0 for TIMEOUT_CYCLES cycles -> PRST with fault_count incremented.
REQ-018 STAB: pll_rst=0 and sys_rst=1; the counter shall count cycles with lk=1; lk=0 -> WAIT with no fault; the STABLE_CYCLES-th consecutive lk=1 cycle -> RUN.
REQ-019 RUN: pll_rst=0, sys_rst=0 and ready=1 from the first cycle state==RUN; lk=0 -> PRST with fault_count incremented.
REQ-020 Outputs shall be registered and decoded from the next state, so sys_rst, ready and pll_rst change on the same edge as the state.
REQ-021 Lock-loss latency: sys_rst=1 no later than SYNC_STAGES+1 rising edges after pll_locked falls, given that pll_locked meets setup.
REQ-022 fault_count shall saturate at 255 with no wrap.
REQ-023 cnt_clr and an increment in the same cycle shall yield 0 (clear wins).
REQ-024 A pll_locked glitch shorter than one clk period may be missed; a pll_locked low pulse of at least one period shall be detected in RUN.
REQ-025 There shall be no combinational path from any input to any output.

Reset
REQ-026 On rst asserted, asynchronously: state=PRST, counter=0, synchroniser flops=0, pll_rst=1, sys_rst=1, ready=0, fault_count=0.
REQ-027 On rst deassertion, the FSM shall begin PRST counting on the first clk edge; the RST_CYCLES pulse shall always complete in full.
REQ-028 rst asserted in any state, mid-count, shall return to the REQ-026 values immediately.

Verification (bench params: SYNC_STAGES=2, RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32)
REQ-029 Clean bring-up: release rst with pll_locked=1 constant -> pll_rst high for 4 cycles; WAIT lasts 1 cycle; 8 cycles in STAB; sys_rst falls and ready rises together; fault_count=0.
REQ-030 Timeout: pll_locked=0 forever -> pll_rst pulses 4 cycles every 4+32 cycles; fault_count increments per pulse and sticks at 255.
REQ-031 Unstable lock: in STAB, drop pll_locked for 1 cycle after 5 high cycles -> return to WAIT, no fault; the next 8 consecutive high cycles -> RUN.
REQ-032 Lock loss: in RUN, drop pll_locked -> sys_rst=1 and ready=0 within 3 edges; pll_rst=1 for 4 cycles; fault_count +1; relock re-enters RUN.
REQ-033 Clear collision: assert cnt_clr on the same cycle as a RUN lock loss -> fault_count=0 next cycle.
REQ-034 Reset mid-STAB: assert rst asynchronously between edges -> pll_rst=1, sys_rst=1, ready=0 and fault_count=0 before the next edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for stable lock, then releases the system reset
module pll_lock_supervisor #(
   parameter int SYNC_STAGES    = 2,
   parameter int RST_CYCLES     = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       cnt_clr,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic [7:0] fault_count
);
   localparam int MAX_RS = RST_CYCLES > STABLE_CYCLES ? RST_CYCLES : STABLE_CYCLES;
   localparam int MAXC   = MAX_RS > TIMEOUT_CYCLES ? MAX_RS : TIMEOUT_CYCLES;
   localparam int CW     = $clog2(MAXC);
   localparam logic [CW-1:0] R_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] S_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {PRST, WAIT, STAB, RUN} state_t;

   state_t                 state, nxt;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   lk, inc;

   assign lk = sync[SYNC_STAGES-1];

   // pll_locked is asynchronous; only the last stage feeds the FSM
   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], pll_locked};

   // next state and fault event from the shared counter and synchronised lock
   always_comb begin
      nxt = state;
      inc = 1'b0;
      case (state)
         PRST:    if (cnt == R_LAST) nxt = WAIT;
         WAIT:    if (lk) nxt = STAB;
                  else if (cnt == T_LAST) begin nxt = PRST; inc = 1'b1; end
         STAB:    if (!lk) nxt = WAIT;
                  else if (cnt == S_LAST) nxt = RUN;
         default: if (!lk) begin nxt = PRST; inc = 1'b1; end
      endcase
   end

   // state, counter and outputs all register the next state on one edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= PRST;
         cnt     <= '0;
         pll_rst <= 1'b1;
         sys_rst <= 1'b1;
         ready   <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= (nxt != state || state == RUN) ? '0 : cnt + 1'b1;
         pll_rst <= nxt == PRST;
         sys_rst <= nxt != RUN;
         ready   <= nxt == RUN;
      end

   // saturating fault counter; a clear beats a simultaneous increment
   always_ff @(posedge clk or posedge rst)
      if (rst) fault_count <= '0;
      else     fault_count <= cnt_clr ? 8'd0 :
                              (inc && fault_count != 8'hff) ? fault_count + 8'd1 : fault_count;
endmodule
